// File: rtl/prpg_pkg.sv
// prpg_pkg: shared types and the Galois LFSR step used by the pattern
// generator and the stream checker.
//   pat_t       : 8-bit pattern, bit 0 leftmost
//   tap_t       : 7-bit tap vector tap[6:0]
//   chk_state_e : checker synchronisation states
//   lfsr_next() : one Galois step of a pattern under a tap vector
package prpg_pkg;

  typedef logic [0:7] pat_t;
  typedef logic [6:0] tap_t;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} chk_state_e;

  // Bit 7 is the feedback bit: it wraps to bit 0 and is XORed into every
  // tapped position as the word shifts right by one.
  function automatic pat_t lfsr_next(pat_t c, tap_t tap);
    pat_t n;
    n[0] = c[7];
    for (int i = 1; i < 8; i++) n[i] = c[i-1] ^ (tap[7-i] & c[7]);
    return n;
  endfunction

endpackage

// File: rtl/prpg_popcnt8.sv
// prpg_popcnt8: combinational population count of an 8-bit word.
//   i_data : word to count
//   o_cnt  : number of set bits (0..8)
module prpg_popcnt8
  import prpg_pkg::*;
(
  input  pat_t       i_data,
  output logic [3:0] o_cnt
);

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < 8; i++) o_cnt = o_cnt + {3'b000, i_data[i]};
  end

endmodule

// File: rtl/prpg_stream_checker.sv
// prpg_stream_checker: receive-side checker for an LFSR pattern stream.
// Seeds a predictor from received words (HUNT -> VERIFY), declares lock after
// LOCK_CNT consecutive correct predictions, then flywheels and accumulates
// word and bit error statistics until LOSS_CNT consecutive misses.
//   clk, rst        : clock, synchronous active-high reset
//   cfg_we, cfg_tap : tap load (forces re-hunt, counters kept)
//   in_valid,in_data: received pattern stream (always ready)
//   clr_cnt         : clear both error counters
//   locked          : high while LOCKED
//   err_pulse       : one-cycle pulse after a locked mismatch
//   hd_last         : Hamming distance of the latest locked compare
//   err_cnt         : saturating mismatched-word count
//   bit_err_cnt     : saturating sum of bit errors over mismatched words
//   signature       : MISR signature, only when PRPG_CHK_MISR_EN is defined
module prpg_stream_checker
  import prpg_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [6:0]       cfg_tap,
  input  logic             in_valid,
  input  logic [0:7]       in_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [3:0]       hd_last,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_err_cnt,
  output logic [0:7]       signature
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(LOSS_CNT - 1);
  // Bit sum is kept 4 bits wider so a per-word distance of up to 8 can
  // never wrap before the saturation test, even for tiny CNT_W.
  localparam logic [CNT_W+3:0] SUM_MAX = {4'b0000, {CNT_W{1'b1}}};

  chk_state_e       r_state;
  tap_t             r_tap;
  pat_t             r_exp;
  logic [GW-1:0]    r_good;
  logic [BW-1:0]    r_bad;
  logic             r_err_pulse;
  logic [3:0]       r_hd;
  logic [CNT_W-1:0] r_err;
  logic [CNT_W-1:0] r_bit;

  pat_t             w_pred_step;
  pat_t             w_seed_step;
  logic [3:0]       w_hd;
  logic             w_mis;
  logic             w_word;
  logic             w_hit;
  logic [CNT_W+3:0] w_bit_sum;

  assign w_pred_step = lfsr_next(r_exp, r_tap);
  assign w_seed_step = lfsr_next(in_data, r_tap);
  assign w_mis       = (in_data != r_exp);
  // A word coinciding with a tap load is dropped entirely.
  assign w_word      = in_valid & ~cfg_we;
  assign w_hit       = w_word & (r_state == LOCKED) & w_mis;
  assign w_bit_sum   = (CNT_W+4)'(r_bit) + (CNT_W+4)'(w_hd);

  prpg_popcnt8 u_popcnt (
    .i_data (in_data ^ r_exp),
    .o_cnt  (w_hd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HUNT;
      r_tap       <= '0;
      r_exp       <= '0;
      r_good      <= '0;
      r_bad       <= '0;
      r_err_pulse <= 1'b0;
      r_hd        <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      if (cfg_we) begin
        r_tap   <= cfg_tap;
        r_state <= HUNT;
        r_good  <= '0;
        r_bad   <= '0;
      end else if (in_valid) begin
        unique case (r_state)
          HUNT: begin
            // All-zero is the LFSR lock-up state and cannot seed a stream.
            if (in_data != '0) begin
              r_exp   <= w_seed_step;
              r_good  <= '0;
              r_state <= VERIFY;
            end
          end
          VERIFY: begin
            r_exp <= w_seed_step;
            if (!w_mis) begin
              r_good <= r_good + 1'b1;
              if (r_good == GOOD_LAST) begin
                r_state <= LOCKED;
                r_bad   <= '0;
              end
            end else begin
              r_good <= '0;
              if (in_data == '0) r_state <= HUNT;
            end
          end
          LOCKED: begin
            // Flywheel on the prediction so corrupted words never re-seed.
            r_exp <= w_pred_step;
            r_hd  <= w_hd;
            if (!w_mis) begin
              r_bad <= '0;
            end else begin
              r_err_pulse <= 1'b1;
              r_bad       <= r_bad + 1'b1;
              if (r_bad == BAD_LAST) r_state <= HUNT;
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_err <= '0;
      r_bit <= '0;
    end else if (w_hit) begin
      if (r_err != {CNT_W{1'b1}}) r_err <= r_err + 1'b1;
      r_bit <= (w_bit_sum > SUM_MAX) ? {CNT_W{1'b1}} : w_bit_sum[CNT_W-1:0];
    end
  end

`ifdef PRPG_CHK_MISR_EN
  pat_t r_sig;

  always_ff @(posedge clk) begin
    if (rst || cfg_we) begin
      r_sig <= '0;
    end else if (in_valid && r_state == LOCKED) begin
      r_sig <= lfsr_next(r_sig, r_tap) ^ in_data;
    end
  end

  assign signature = r_sig;
`else
  assign signature = '0;
`endif

  assign locked      = (r_state == LOCKED);
  assign err_pulse   = r_err_pulse;
  assign hd_last     = r_hd;
  assign err_cnt     = r_err;
  assign bit_err_cnt = r_bit;

endmodule
